// File: rtl/washing_machine_fsm.sv
`default_nettype none
// ============================================================================
// Module   : washing_machine_fsm
// Brief    : Wash-cycle controller. A 4-bit run timer plus a 7-state Moore FSM
//            that steps through each phase when the timer hits fixed values.
// Revision : 1.0 - initial release
// ============================================================================
module washing_machine_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    output logic       o,
    output logic [2:0] state,
    output logic [3:0] count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_FILL  = 3'b001,
        S_WASH  = 3'b010,
        S_DRAIN = 3'b011,
        S_RINSE = 3'b100,
        S_SPIN  = 3'b101,
        S_DONE  = 3'b110
    } state_t;

    localparam logic [3:0] c_FILL_END  = 4'd2;
    localparam logic [3:0] c_WASH_END  = 4'd5;
    localparam logic [3:0] c_DRAIN_END = 4'd7;
    localparam logic [3:0] c_RINSE_END = 4'd10;
    localparam logic [3:0] c_SPIN_END  = 4'd13;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_count;
    logic       w_en;

    assign w_en = start & ~pause;

    // The timer never clears from the FSM, so it wraps freely 15 -> 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_en) begin
                r_count <= r_count + 4'd1;
            end
        end
    end

    // Thresholds are compared against the pre-increment timer value.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)                 w_next = S_FILL;
            S_FILL:  if (r_count == c_FILL_END)  w_next = S_WASH;
            S_WASH:  if (r_count == c_WASH_END)  w_next = S_DRAIN;
            S_DRAIN: if (r_count == c_DRAIN_END) w_next = S_RINSE;
            S_RINSE: if (r_count == c_RINSE_END) w_next = S_SPIN;
            S_SPIN:  if (r_count == c_SPIN_END)  w_next = S_DONE;
            S_DONE:  if (!start)                w_next = S_IDLE;
            default:                            w_next = S_IDLE;
        endcase
    end

    assign o     = (r_state == S_DONE);
    assign state = r_state;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_washing_machine_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_washing_machine_fsm
// Brief    : Directed, table-driven bench for washing_machine_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_washing_machine_fsm;

    logic       clk;
    logic       reset;
    logic       start;
    logic       pause;
    logic       o;
    logic [2:0] state;
    logic [3:0] count;

    int n_cmp;
    int n_bad;

    typedef struct packed {
        logic       rst;
        logic       st;
        logic       pa;
        logic [2:0] es;
        logic [3:0] ec;
        logic       eo;
    } vec_t;

    vec_t tbl[$];

    washing_machine_fsm u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .pause (pause),
        .o     (o),
        .state (state),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic rs, input logic st, input logic pa,
                       input logic [2:0] es, input logic [3:0] ec, input logic eo);
        vec_t v;
        v.rst = rs; v.st = st; v.pa = pa; v.es = es; v.ec = ec; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [2:0] es,
                         input logic [3:0] ec, input logic eo);
        n_cmp++;
        if (state !== es) begin
            n_bad++;
            $display("FAIL %s state: got %b want %b", nm, state, es);
        end
        n_cmp++;
        if (count !== ec) begin
            n_bad++;
            $display("FAIL %s count: got %0d want %0d", nm, count, ec);
        end
        n_cmp++;
        if (o !== eo) begin
            n_bad++;
            $display("FAIL %s o: got %b want %b", nm, o, eo);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input string nm, input logic rs, input logic st, input logic pa,
                        input logic [2:0] es, input logic [3:0] ec, input logic eo);
        @(negedge clk);
        reset = rs;
        start = st;
        pause = pa;
        @(posedge clk);
        #1;
        check(nm, es, ec, eo);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        start = 1'b1;
        pause = 1'b0;

        // Reset with start held, then the nominal run (count == edge number).
        add(0, 1, 0, 3'd0, 4'd0, 0);
        add(0, 1, 0, 3'd0, 4'd0, 0);
        add(1, 1, 0, 3'd1, 4'd1, 0);
        add(1, 1, 0, 3'd1, 4'd2, 0);
        add(1, 1, 0, 3'd2, 4'd3, 0);
        add(1, 1, 0, 3'd2, 4'd4, 0);
        add(1, 1, 0, 3'd2, 4'd5, 0);
        add(1, 1, 0, 3'd3, 4'd6, 0);
        add(1, 1, 0, 3'd3, 4'd7, 0);
        add(1, 1, 0, 3'd4, 4'd8, 0);
        add(1, 1, 0, 3'd4, 4'd9, 0);
        add(1, 1, 0, 3'd4, 4'd10, 0);
        add(1, 1, 0, 3'd5, 4'd11, 0);
        add(1, 1, 0, 3'd5, 4'd12, 0);
        add(1, 1, 0, 3'd5, 4'd13, 0);
        add(1, 1, 0, 3'd6, 4'd14, 1);
        // Hold start in Done: timer wraps, Done persists.
        add(1, 1, 0, 3'd6, 4'd15, 1);
        add(1, 1, 0, 3'd6, 4'd0, 1);
        add(1, 1, 0, 3'd6, 4'd1, 1);
        // Drop start in Done: back to Idle, timer holds.
        add(1, 0, 0, 3'd0, 4'd1, 0);
        add(1, 0, 0, 3'd0, 4'd1, 0);
        // Pause for 4 cycles in Wash at count 3; Drain slips to edge 10.
        add(0, 1, 0, 3'd0, 4'd0, 0);
        add(1, 1, 0, 3'd1, 4'd1, 0);
        add(1, 1, 0, 3'd1, 4'd2, 0);
        add(1, 1, 0, 3'd2, 4'd3, 0);
        add(1, 1, 1, 3'd2, 4'd3, 0);
        add(1, 1, 1, 3'd2, 4'd3, 0);
        add(1, 1, 1, 3'd2, 4'd3, 0);
        add(1, 1, 1, 3'd2, 4'd3, 0);
        add(1, 1, 0, 3'd2, 4'd4, 0);
        add(1, 1, 0, 3'd2, 4'd5, 0);
        add(1, 1, 0, 3'd3, 4'd6, 0);
        // Dropping start mid-cycle freezes the timer but keeps the phase.
        add(1, 0, 0, 3'd3, 4'd6, 0);
        add(1, 0, 0, 3'd3, 4'd6, 0);
        add(1, 1, 0, 3'd3, 4'd7, 0);
        add(1, 1, 0, 3'd4, 4'd8, 0);

        foreach (tbl[i]) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].st, tbl[i].pa,
                 tbl[i].es, tbl[i].ec, tbl[i].eo);
        end

        // Restart from Idle with count 14: Fill waits for the wrap to 2.
        step("rst2", 0, 1, 0, 3'd0, 4'd0, 0);
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            reset = 1'b1;
            start = 1'b1;
            pause = 1'b0;
        end
        @(posedge clk);
        #1;
        check("run14", 3'd6, 4'd14, 1'b1);
        step("idle14", 1, 0, 0, 3'd0, 4'd14, 0);
        step("rs_a1", 1, 1, 0, 3'd1, 4'd15, 0);
        step("rs_a2", 1, 1, 0, 3'd1, 4'd0, 0);
        step("rs_a3", 1, 1, 0, 3'd1, 4'd1, 0);
        step("rs_a4", 1, 1, 0, 3'd1, 4'd2, 0);
        step("rs_a5", 1, 1, 0, 3'd2, 4'd3, 0);
        step("rs_a6", 1, 1, 0, 3'd2, 4'd4, 0);
        step("rs_a7", 1, 1, 0, 3'd2, 4'd5, 0);
        step("rs_a8", 1, 1, 0, 3'd3, 4'd6, 0);
        step("rs_a9", 1, 1, 0, 3'd3, 4'd7, 0);
        step("rs_a10", 1, 1, 0, 3'd4, 4'd8, 0);

        // Reset in Rinse overrides start.
        step("rst_rinse", 0, 1, 0, 3'd0, 4'd0, 0);
        step("rst_hold", 0, 1, 1, 3'd0, 4'd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/washing_machine_fsm.md
# washing_machine_fsm

Washing-machine cycle controller: a 4-bit run timer plus a 7-state Moore FSM that sequences Idle → Fill → Wash → Drain → Rinse → Spin → Done against absolute timer values. It sits directly under the board-level top, driven by the start and pause buttons. It exposes the done flag, the current state and the timer count for top-level checks and coverage.

## Interface
- No parameters. Widths are fixed: timer 4 bits, state 3 bits.
- `clk` in 1: single system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low; sampled on the rising edge of `clk`.
- `start` in 1: start button, level-sensitive, held high for the whole cycle.
- `pause` in 1: pause button, level-sensitive; freezes the timer.
- `o` out 1: done flag; 1 exactly when state is Done.
- `state` out 3: current FSM state encoding.
- `count` out 4: current timer value.

## Operation
- Timer enable is `start & ~pause`.
  - Enabled: `count` increments by 1 per clock.
  - Disabled: `count` holds.
  - Wraps 15 → 0 with no flag.
  - Cleared only by reset; no clear from the FSM.
- State encoding: Idle=000, Fill=001, Wash=010, Drain=011, Rinse=100, Spin=101, Done=110. 111 is illegal.
- Transitions are evaluated on the registered `count` value (the value before this edge's increment):
  - Idle → Fill when `start`=1; otherwise stay.
  - Fill → Wash when `count`==2.
  - Wash → Drain when `count`==5.
  - Drain → Rinse when `count`==7.
  - Rinse → Spin when `count`==10.
  - Spin → Done when `count`==13.
  - Done → Idle when `start`=0; stay in Done while `start`=1.
  - 111 → Idle on the next edge.
- `start` and `pause` have no direct effect in Fill..Spin. They matter only through the timer, so a phase stretches while the timer is frozen.
- If the timer is already past a phase threshold when that phase is entered, the FSM waits for wrap-around. Example: restart from Idle with `count`=15 → Fill exits after the count wraps to 2.
- `o` = (state==Done). It is a combinational decode of the state register, never asserted in any other state.

## Timing
- Reset (`reset`=0 at an edge): `state`=Idle, `count`=0, `o`=0 after that edge. Reset overrides all other inputs, including mid-cycle.
- Idle → Fill: one edge after `start` is sampled high.
  - The timer also increments on that same edge, since enable depends only on the inputs.
- A phase exits one edge after `count` reaches its threshold.
- Run from reset with `start`=1, `pause`=0 held from edge 1 (all edge numbers counted from edge 1):

| State | Entered at edge |
|---|---|
| Fill | 1 |
| Wash | 3 |
| Drain | 6 |
| Rinse | 8 |
| Spin | 11 |
| Done | 14 (`o`=1 from edge 14) |

- Pausing freezes `count`. The FSM holds its phase for the entire pause, then resumes the same schedule shifted by the pause length.
- Dropping `start` mid-cycle also freezes the timer, but the FSM stays in its phase. Only Done reacts to `start`=0, returning to Idle on the next edge.
- Latency of `o` from entering Done is 0 cycles.

## Test plan
- Reset with `start`=1 held → after the edge: `state`=000, `count`=0, `o`=0. Release reset → `state` trace 001@1, 010@3, 011@6, 100@11-shifted-free i.e. 100@8, 101@11, 110@14 with `o`=1.
- Pause high for 4 cycles while in Wash (`count`=3) → `count` stays 3, `state` stays 010. Release → Drain entered 4 edges later than nominal (edge 10).
- In Done, drop `start` → `state`=000 and `o`=0 after the next edge; `count` holds.
- Hold `start`=1 in Done → `count` wraps 15 → 0, `state` stays 110, `o` stays 1.
- Restart from Idle with `count`=14 → Fill persists until the wrap to 2 (edge 4 after start), then Wash.
- Assert `reset`=0 during Rinse → `state`=000, `count`=0, `o`=0 on that edge. Every cycle: `o`==1 iff `state`==110.
